// File: rtl/vpu_pkg.sv
// vpu_pkg: shared definitions for the vector unit, also used by CPU decode.
//   - opcode constants for the seven vector instructions
//   - alu_op encodings driven to the lane datapath
//   - FSM state encoding for vpu_control
//   - small opcode classification helpers
package vpu_pkg;

    localparam logic [4:0] OP_VADD  = 5'b10000;
    localparam logic [4:0] OP_VSUB  = 5'b10001;
    localparam logic [4:0] OP_VMUL  = 5'b10010;
    localparam logic [4:0] OP_VSMUL = 5'b10011;
    localparam logic [4:0] OP_VDOT  = 5'b10100;
    localparam logic [4:0] OP_VLD   = 5'b10101;
    localparam logic [4:0] OP_VST   = 5'b10110;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_MUL  = 2'b10;
    localparam logic [1:0] ALU_SMUL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_WB   = 3'd2,
        S_MEM  = 3'd3,
        S_DONE = 3'd4
    } vpu_state_t;

    function automatic logic is_arith(input logic [4:0] op);
        return (op == OP_VADD) || (op == OP_VSUB) || (op == OP_VMUL) || (op == OP_VSMUL);
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_VLD) || (op == OP_VST);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return is_arith(op) || is_mem(op) || (op == OP_VDOT);
    endfunction

    function automatic logic [1:0] alu_of(input logic [4:0] op);
        logic [1:0] a;
        case (op)
            OP_VSUB:  a = ALU_SUB;
            OP_VMUL:  a = ALU_MUL;
            OP_VSMUL: a = ALU_SMUL;
            OP_VDOT:  a = ALU_MUL;
            default:  a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/vpu_control_if.sv
// vpu_control_if: CPU <-> VPU control handshake and lane strobe bundle.
//   master: CPU/pipeline side (drives VPU_start, opcode, mem_ack)
//   slave : vpu_control (drives VPU_rdy, lane, alu_op and all strobes)
interface vpu_control_if #(parameter int LW = 2);
    logic          VPU_start;
    logic [4:0]    opcode;
    logic          mem_ack;
    logic          VPU_rdy;
    logic [LW-1:0] lane;
    logic [1:0]    alu_op;
    logic          vreg_we;
    logic          acc_clr;
    logic          acc_en;
    logic          sreg_we;
    logic          mem_re;
    logic          mem_we;
    logic          illegal;

    modport master (
        output VPU_start, opcode, mem_ack,
        input  VPU_rdy, lane, alu_op, vreg_we, acc_clr, acc_en, sreg_we,
               mem_re, mem_we, illegal
    );

    modport slave (
        input  VPU_start, opcode, mem_ack,
        output VPU_rdy, lane, alu_op, vreg_we, acc_clr, acc_en, sreg_we,
               mem_re, mem_we, illegal
    );
endinterface

// File: rtl/vpu_lane_ctr.sv
// vpu_lane_ctr: lane index counter for the vector sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force lane to 0 (instruction accept)
//   inc        : advance one lane; saturates at NLANES-1
//   lane       : current lane index
//   last       : lane == NLANES-1
module vpu_lane_ctr #(
    parameter int NLANES = 3,
    parameter int LW     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [LW-1:0] lane,
    output logic          last
);
    assign last = (lane == LW'(NLANES - 1));

    // Saturating so the index can never run past the last lane.
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            lane <= '0;
        else if (inc && !last)
            lane <= lane + LW'(1);
    end
endmodule

// File: rtl/vpu_control.sv
// vpu_control: sequencer for 3-lane vector instructions.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : vpu_control_if slave (start/opcode/mem_ack in; ready,
//                lane, alu_op and datapath/memory strobes out)
// Arith ops sweep lanes in EXEC writing the vector file; VDOT sweeps in
// EXEC accumulating, then writes the scalar in WB; VLD/VST step lanes on
// each mem_ack in MEM. DONE is the single retire cycle.
module vpu_control
    import vpu_pkg::*;
#(
    parameter int NLANES = 3,
    parameter int LW     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    vpu_control_if.slave  bus
);
    vpu_state_t    state;
    logic [4:0]    op_q;
    logic [LW-1:0] lane;
    logic          lane_last;
    logic          accept;
    logic          lane_inc;

    assign accept   = (state == S_IDLE) && bus.VPU_start;
    assign lane_inc = (state == S_EXEC) || ((state == S_MEM) && bus.mem_ack);

    vpu_lane_ctr #(.NLANES(NLANES), .LW(LW)) u_lane_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (lane_inc),
        .lane  (lane),
        .last  (lane_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.VPU_start) begin
                    op_q <= bus.opcode;
                    if (is_arith(bus.opcode) || bus.opcode == OP_VDOT) state <= S_EXEC;
                    else if (is_mem(bus.opcode))                        state <= S_MEM;
                    else                                                state <= S_DONE;
                end
                S_EXEC: if (lane_last) state <= (op_q == OP_VDOT) ? S_WB : S_DONE;
                S_WB:   state <= S_DONE;
                S_MEM:  if (bus.mem_ack && lane_last) state <= S_DONE;
                // Start is still high here for the retiring instruction.
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from registered state; only the VLD write depends on
    // the live ack so data is captured in the same cycle memory returns it.
    always_comb begin
        bus.VPU_rdy = (state == S_DONE) || ((state == S_IDLE) && !bus.VPU_start);
        bus.lane    = lane;
        bus.alu_op  = ALU_ADD;
        bus.vreg_we = 1'b0;
        bus.acc_clr = 1'b0;
        bus.acc_en  = 1'b0;
        bus.sreg_we = 1'b0;
        bus.mem_re  = 1'b0;
        bus.mem_we  = 1'b0;
        bus.illegal = 1'b0;
        case (state)
            S_EXEC: begin
                bus.alu_op = alu_of(op_q);
                if (op_q == OP_VDOT) begin
                    bus.acc_en  = 1'b1;
                    bus.acc_clr = (lane == '0);
                end else begin
                    bus.vreg_we = 1'b1;
                end
            end
            S_WB:   bus.sreg_we = 1'b1;
            S_MEM: begin
                bus.mem_re  = (op_q == OP_VLD);
                bus.mem_we  = (op_q == OP_VST);
                bus.vreg_we = (op_q == OP_VLD) && bus.mem_ack;
            end
            S_DONE: bus.illegal = !is_legal(op_q);
            default: ;
        endcase
    end
endmodule
